if_id_stage: RTL and testbench
==============================

# if_id_stage

Fetch-side front end of the WISC-S15 five-stage pipeline: owns the PC register and the IF/ID pipeline register, and feeds the decoded register fields to the hazard detection unit. It consumes that unit's `hazard` output to freeze fetch, and EX-stage branch resolution to redirect and flush. It also tells the ID/EX register when to load a bubble, and freezes the front end on HLT.

## Interface
- `PC_W`, 16: PC and instruction-address width.
- `INSTR_W`, 16: instruction width; fields are opcode [15:12], rd [11:8], rs [7:4], rt [3:0].
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `MAX_STALL`, 3: longest legal run of consecutive stall cycles.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hazard` in 1: RAW hazard against the IF/ID instruction, from the hazard detection unit.
- `branch_taken` in 1: EX stage resolved a taken branch or jump.
- `branch_target` in PC_W: redirect address, valid with `branch_taken`.
- `instr_in` in INSTR_W: instruction memory read data for `pc`, combinational, same cycle.
- `pc` out PC_W: fetch address.
- `IF_ID_instr` out INSTR_W: registered instruction.
- `IF_ID_pc_plus1` out PC_W: registered fetch PC + 1.
- `IF_ID_valid` out 1: IF/ID holds a real instruction.
- `IF_ID_reg_rs`, `IF_ID_reg_rt`, `IF_ID_reg_rd` out 4 each: fields of `IF_ID_instr`; forced to 4'h0 when `IF_ID_valid`=0.
- `ID_EX_bubble` out 1: ID/EX must load a NOP this edge.
- `halted` out 1: front end frozen by HLT.
- `stall_err` out 1: sticky stall-watchdog flag.

## Operation
- States: RUN, STALL, HALT. Per-edge priority: reset > flush > stall > halt capture > advance.
- `hz` = `hazard` & `IF_ID_valid`. The `hazard` input is ignored when the IF/ID register holds a bubble.
- **Flush** (`branch_taken`=1, any state except HALT):
  - `pc` <= `branch_target`; `IF_ID_valid` <= 0; state <= RUN.
  - Flush overrides a simultaneous `hz` and a simultaneous HLT in ID, because both are wrong-path.
- **Stall** (`hz`=1, no flush):
  - `pc`, `IF_ID_*` and `IF_ID_valid` hold.
  - State is STALL.
- **Halt capture** (no flush, no `hz`, `IF_ID_valid`=1, opcode 4'hF):
  - HLT issues to ID/EX.
  - `IF_ID_valid` <= 0; `pc` holds; state <= HALT.
- **Advance**:
  - `IF_ID_instr` <= `instr_in`; `IF_ID_pc_plus1` <= `pc`+1; `IF_ID_valid` <= 1; `pc` <= `pc`+1.
  - State is RUN.
- **HALT**: `pc` and the IF/ID register are frozen; `halted`=1; `branch_taken` is ignored. Only reset exits HALT.
- `ID_EX_bubble` (combinational) = `hz` | `branch_taken` | !`IF_ID_valid` | (state==HALT).
- PC arithmetic wraps modulo 2^PC_W, so 16'hFFFF + 1 = 16'h0000. No carry is kept.

## Timing
- Reset values:
  - `pc`=RESET_PC; `IF_ID_instr`=0; `IF_ID_pc_plus1`=0; `IF_ID_valid`=0.
  - State RUN; `halted`=0; stall counter 0; `stall_err`=0.
- Fetch latency is one edge from `pc` to `IF_ID_instr`. The first valid IF/ID word appears after the first rising edge following `rst_n` deassertion.
- Branch penalty is one IF/ID bubble: the edge on which `branch_taken` is seen loads the target into `pc`, and the next edge captures the target instruction.
- A stall lasts exactly as long as `hz` is high. The edge after `hz` falls performs a normal advance.
- Asserting reset mid-stall or in HALT returns all outputs to their reset values immediately (asynchronous).

## Configuration
- `STALL_WDOG_EN` defined:
  - A 2-bit counter increments on each stall edge, saturates, and clears on any non-stall edge.
  - If `hz` is still 1 when the counter equals MAX_STALL, `stall_err` sets and stays set until reset.
- `STALL_WDOG_EN` undefined: no counter is built and `stall_err` is tied to 0.

## Structure
- Shared package `wisc_pkg` holds:
  - the opcode localparams (`OP_HLT` = 4'hF);
  - the instruction field bit positions;
  - the state enum {RUN, STALL, HALT}.
- One sub-module, `pc_reg`: PC flop with hold, load and increment, plus the reset value.

## Test plan
- **Reset and streaming:** reset, then memory returns 16'h1210, 16'h2321, … → `pc` steps 0, 1, 2; `IF_ID_instr`=16'h1210 after edge 1; `ID_EX_bubble`=1 only in cycle 0.
- **Hazard stall:** `hazard`=1 for 2 cycles with IF/ID valid → `pc` and `IF_ID_instr` frozen for 2 edges with `ID_EX_bubble`=1; the third edge advances.
- **Branch vs. stall:** `branch_taken`=1 with `branch_target`=16'h0040 while `hazard`=1 → `pc`=16'h0040 and `IF_ID_valid`=0 after one edge; the next edge loads the instruction at 16'h0040.
- **Halt:** HLT (16'hF000) reaches IF/ID → after one edge `halted`=1, `pc` frozen, and a later `branch_taken` pulse has no effect; `rst_n` low restores `pc`=RESET_PC.
- **Watchdog** (`STALL_WDOG_EN` defined): `hazard` held for 4 cycles → `stall_err` rises at the 4th stall cycle and stays 1 after `hazard` drops.
- **PC wrap:** `branch_target`=16'hFFFF → the next advance gives `pc`=16'h0000 and `IF_ID_pc_plus1`=16'h0000.

Source files
------------

// File: rtl/wisc_pkg.sv
// wisc_pkg: shared opcodes, instruction field positions and front-end state type
package wisc_pkg;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 0;
  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
endpackage

// File: rtl/if_id_stage_pc_reg.sv
// pc_reg: program counter with branch load, sequential increment and hold
module pc_reg #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);
  // load wins over increment; the add wraps naturally at PC_W bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else pc <= load ? load_val : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC + IF/ID register with stall, branch flush and HLT freeze; optional STALL_WDOG_EN watchdog
module if_id_stage
  import wisc_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int MAX_STALL = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hazard,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [PC_W-1:0]    IF_ID_pc_plus1,
  output logic               IF_ID_valid,
  output logic [3:0]         IF_ID_reg_rs,
  output logic [3:0]         IF_ID_reg_rt,
  output logic [3:0]         IF_ID_reg_rd,
  output logic               ID_EX_bubble,
  output logic               halted,
  output logic               stall_err
);
  state_t state, state_nx;
  logic hz, flush, halt_cap, adv;
  assign hz = hazard & IF_ID_valid;
  assign flush = branch_taken & (state != HALT);
  assign halt_cap = !flush & !hz & IF_ID_valid & (IF_ID_instr[OP_MSB:OP_LSB] == OP_HLT);
  assign adv = !flush & !hz & !halt_cap & (state != HALT);
  pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .load(flush), .load_val(branch_target), .inc(adv), .pc(pc)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  // HALT is absorbing; otherwise priority flush > stall > halt capture > advance
  always_comb begin
    state_nx = state;
    state_nx = (state == HALT) ? HALT : flush ? RUN : hz ? STALL : halt_cap ? HALT : RUN;
  end
  // IF/ID register: flush and halt capture drop valid, stall and HALT hold, advance loads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      IF_ID_instr <= '0;
      IF_ID_pc_plus1 <= '0;
      IF_ID_valid <= 1'b0;
    end else if (flush || halt_cap) begin
      IF_ID_valid <= 1'b0;
    end else if (adv) begin
      IF_ID_instr <= instr_in;
      IF_ID_pc_plus1 <= pc + 1'b1;
      IF_ID_valid <= 1'b1;
    end
  assign IF_ID_reg_rs = IF_ID_valid ? IF_ID_instr[RS_MSB:RS_LSB] : 4'h0;
  assign IF_ID_reg_rt = IF_ID_valid ? IF_ID_instr[RT_MSB:RT_LSB] : 4'h0;
  assign IF_ID_reg_rd = IF_ID_valid ? IF_ID_instr[RD_MSB:RD_LSB] : 4'h0;
  assign halted = (state == HALT);
  assign ID_EX_bubble = hz | branch_taken | !IF_ID_valid | halted;
`ifdef STALL_WDOG_EN
  logic [1:0] stall_cnt;
  // saturating run-length of stall edges; flag sticks once a stall outlasts MAX_STALL
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= 2'd0;
      stall_err <= 1'b0;
    end else if (hz && !flush) begin
      stall_cnt <= (stall_cnt == 2'd3) ? 2'd3 : stall_cnt + 2'd1;
      if (stall_cnt == 2'(MAX_STALL)) stall_err <= 1'b1;
    end else begin
      stall_cnt <= 2'd0;
    end
`else
  assign stall_err = 1'b0;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scoreboard bench for the fetch front end
module tb_if_id_stage;
  localparam bit WD =
`ifdef STALL_WDOG_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {
    string tag;
    logic [31:0] v;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, hazard = 1'b0, branch_taken = 1'b0;
  logic [15:0] branch_target = '0, instr_in, pc, IF_ID_instr, IF_ID_pc_plus1;
  logic [15:0] hlt_addr = 16'h8000;
  logic IF_ID_valid, ID_EX_bubble, halted, stall_err;
  logic [3:0] IF_ID_reg_rs, IF_ID_reg_rt, IF_ID_reg_rd;
  exp_t exp_q[$];
  int checks = 0, failures = 0;
  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_in(instr_in), .pc(pc), .IF_ID_instr(IF_ID_instr),
    .IF_ID_pc_plus1(IF_ID_pc_plus1), .IF_ID_valid(IF_ID_valid), .IF_ID_reg_rs(IF_ID_reg_rs),
    .IF_ID_reg_rt(IF_ID_reg_rt), .IF_ID_reg_rd(IF_ID_reg_rd), .ID_EX_bubble(ID_EX_bubble),
    .halted(halted), .stall_err(stall_err)
  );
  always #5 clk = ~clk;
  // memory: {addr%14+1, a+2, a+1, a} per nibble, so addr 0 -> 1210, 1 -> 2321; HLT at hlt_addr
  always_comb begin
    instr_in = 16'h0;
    instr_in = (pc == hlt_addr) ? 16'hF000 :
               {4'(pc % 16'd14 + 16'd1), pc[3:0] + 4'd2, pc[3:0] + 4'd1, pc[3:0]};
  end
  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    exp_q.push_back(e);
  endtask
  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.tag = "queue_underflow";
      e.v = 32'hDEAD_BEEF;
    end else e = exp_q.pop_front();
    checks++;
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
    end
  endtask
  task automatic now(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push(tag, e);
    cmp(obs);
  endtask
  task automatic step(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                      input logic [15:0] e_p1, input logic e_valid);
    push({tag, ".pc"}, {16'h0, e_pc});
    push({tag, ".instr"}, {16'h0, e_instr});
    push({tag, ".pc_plus1"}, {16'h0, e_p1});
    push({tag, ".valid"}, {31'h0, e_valid});
    @(posedge clk);
    #1;
    cmp({16'h0, pc});
    cmp({16'h0, IF_ID_instr});
    cmp({16'h0, IF_ID_pc_plus1});
    cmp({31'h0, IF_ID_valid});
  endtask
  initial begin
    #2;
    now("rst.pc", {16'h0, pc}, 32'h0);
    now("rst.instr", {16'h0, IF_ID_instr}, 32'h0);
    now("rst.valid", {31'h0, IF_ID_valid}, 32'h0);
    now("rst.halted", {31'h0, halted}, 32'h0);
    now("rst.stall_err", {31'h0, stall_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    now("c0.bubble", {31'h0, ID_EX_bubble}, 32'h1);
    step("stream1", 16'h1, 16'h1210, 16'h1, 1'b1);
    now("stream1.bubble", {31'h0, ID_EX_bubble}, 32'h0);
    now("stream1.rd", {28'h0, IF_ID_reg_rd}, 32'h2);
    now("stream1.rs", {28'h0, IF_ID_reg_rs}, 32'h1);
    now("stream1.rt", {28'h0, IF_ID_reg_rt}, 32'h0);
    step("stream2", 16'h2, 16'h2321, 16'h2, 1'b1);
    hazard = 1'b1;
    #1;
    now("stall.bubble", {31'h0, ID_EX_bubble}, 32'h1);
    step("stall1", 16'h2, 16'h2321, 16'h2, 1'b1);
    step("stall2", 16'h2, 16'h2321, 16'h2, 1'b1);
    hazard = 1'b0;
    #1;
    now("unstall.bubble", {31'h0, ID_EX_bubble}, 32'h0);
    step("unstall", 16'h3, 16'h3432, 16'h3, 1'b1);
    hazard = 1'b1;
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    #1;
    now("br.bubble", {31'h0, ID_EX_bubble}, 32'h1);
    step("br_vs_stall", 16'h0040, 16'h3432, 16'h3, 1'b0);
    now("br.rs_zero", {28'h0, IF_ID_reg_rs}, 32'h0);
    now("br.rd_zero", {28'h0, IF_ID_reg_rd}, 32'h0);
    branch_taken = 1'b0;
    #1;
    now("bubble_ignores_hazard", {31'h0, ID_EX_bubble}, 32'h1);
    step("br_target", 16'h0041, 16'h9210, 16'h0041, 1'b1);
    hazard = 1'b0;
    branch_taken = 1'b1;
    branch_target = 16'hFFFF;
    step("br_ffff", 16'hFFFF, 16'h9210, 16'h0041, 1'b0);
    branch_taken = 1'b0;
    hlt_addr = 16'h0000;
    step("wrap", 16'h0000, 16'h210F, 16'h0000, 1'b1);
    step("hlt_fetch", 16'h0001, 16'hF000, 16'h0001, 1'b1);
    now("hlt_issue.bubble", {31'h0, ID_EX_bubble}, 32'h0);
    now("hlt_issue.halted", {31'h0, halted}, 32'h0);
    step("hlt_cap", 16'h0001, 16'hF000, 16'h0001, 1'b0);
    now("halt.halted", {31'h0, halted}, 32'h1);
    now("halt.bubble", {31'h0, ID_EX_bubble}, 32'h1);
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    hazard = 1'b1;
    step("halt_ignores_br", 16'h0001, 16'hF000, 16'h0001, 1'b0);
    now("halt.halted2", {31'h0, halted}, 32'h1);
    branch_taken = 1'b0;
    hazard = 1'b0;
    rst_n = 1'b0;
    #1;
    now("async_rst.pc", {16'h0, pc}, 32'h0);
    now("async_rst.halted", {31'h0, halted}, 32'h0);
    now("async_rst.instr", {16'h0, IF_ID_instr}, 32'h0);
    hlt_addr = 16'h8000;
    @(negedge clk);
    rst_n = 1'b1;
    step("wd_fill", 16'h1, 16'h1210, 16'h1, 1'b1);
    hazard = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push("wd.stall_err", {31'h0, (i == 4) && WD});
      @(posedge clk);
      #1;
      cmp({31'h0, stall_err});
    end
    now("wd.pc_frozen", {16'h0, pc}, 32'h1);
    hazard = 1'b0;
    push("wd.sticky", {31'h0, WD});
    @(posedge clk);
    #1;
    cmp({31'h0, stall_err});
    now("wd.advance", {16'h0, pc}, 32'h2);
    now("queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
